// File: rtl/pe_core.sv
`default_nettype none
// ============================================================================
// Module   : pe_core
// Purpose  : Two-stage scalar processing element with a private register file
//            and an integer ALU/MAC unit; results forwarded to dependent reads.
// Revision : 1.0 - initial release
// ============================================================================
module pe_core #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic              valid_in,
    output logic [DATA_W-1:0] result_o,
    output logic              result_valid
);

    localparam logic [6:0] c_CLASS_ALU = 7'b0000001;
    localparam logic [4:0] c_OP_ADD  = 5'h01;
    localparam logic [4:0] c_OP_SUB  = 5'h02;
    localparam logic [4:0] c_OP_MUL  = 5'h03;
    localparam logic [4:0] c_OP_AND  = 5'h04;
    localparam logic [4:0] c_OP_OR   = 5'h05;
    localparam logic [4:0] c_OP_XOR  = 5'h06;
    localparam logic [4:0] c_OP_SLL  = 5'h07;
    localparam logic [4:0] c_OP_SRL  = 5'h08;
    localparam logic [4:0] c_OP_SRA  = 5'h09;
    localparam logic [4:0] c_OP_MAX  = 5'h0A;
    localparam logic [4:0] c_OP_MIN  = 5'h0B;
    localparam logic [4:0] c_OP_MAC  = 5'h0C;
    localparam logic [4:0] c_OP_RELU = 5'h0D;
    localparam logic [4:0] c_OP_ADDI = 5'h0E;

    logic [DATA_W-1:0] r_regs [NREGS];

    // Stage-1 (operand) registers
    logic              r_s1_valid;
    logic [4:0]        r_s1_op;
    logic [4:0]        r_s1_rd;
    logic [DATA_W-1:0] r_s1_a;
    logic [DATA_W-1:0] r_s1_b;
    logic [DATA_W-1:0] r_s1_c;
    logic [DATA_W-1:0] r_s1_imm;

    logic [6:0]        w_class;
    logic [4:0]        w_op;
    logic [4:0]        w_rd;
    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic [4:0]        w_imm5;
    logic              w_legal;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_c;
    logic [DATA_W-1:0] w_alu;

    assign w_class = instr[31:25];
    assign w_op    = instr[24:20];
    assign w_rd    = instr[19:15];
    assign w_rs1   = instr[14:10];
    assign w_rs2   = instr[9:5];
    assign w_imm5  = instr[4:0];
    assign w_legal = (w_class == c_CLASS_ALU) && (w_op >= c_OP_ADD) && (w_op <= c_OP_ADDI);

    // Reads see the value stage 2 is writing on this same edge; r0 never forwards.
    assign w_a = (w_rs1 == 5'd0) ? '0 :
                 (r_s1_valid && r_s1_rd == w_rs1) ? w_alu : r_regs[w_rs1];
    assign w_b = (w_rs2 == 5'd0) ? '0 :
                 (r_s1_valid && r_s1_rd == w_rs2) ? w_alu : r_regs[w_rs2];
    assign w_c = (w_rd == 5'd0) ? '0 :
                 (r_s1_valid && r_s1_rd == w_rd) ? w_alu : r_regs[w_rd];

    always_comb begin
        w_alu = '0;
        case (r_s1_op)
            c_OP_ADD:  w_alu = r_s1_a + r_s1_b;
            c_OP_SUB:  w_alu = r_s1_a - r_s1_b;
            c_OP_MUL:  w_alu = r_s1_a * r_s1_b;
            c_OP_AND:  w_alu = r_s1_a & r_s1_b;
            c_OP_OR:   w_alu = r_s1_a | r_s1_b;
            c_OP_XOR:  w_alu = r_s1_a ^ r_s1_b;
            c_OP_SLL:  w_alu = r_s1_a << r_s1_b[4:0];
            c_OP_SRL:  w_alu = r_s1_a >> r_s1_b[4:0];
            c_OP_SRA:  w_alu = $signed(r_s1_a) >>> r_s1_b[4:0];
            c_OP_MAX:  w_alu = ($signed(r_s1_a) > $signed(r_s1_b)) ? r_s1_a : r_s1_b;
            c_OP_MIN:  w_alu = ($signed(r_s1_a) < $signed(r_s1_b)) ? r_s1_a : r_s1_b;
            c_OP_MAC:  w_alu = r_s1_c + r_s1_a * r_s1_b;
            c_OP_RELU: w_alu = r_s1_a[DATA_W-1] ? '0 : r_s1_a;
            c_OP_ADDI: w_alu = r_s1_a + r_s1_imm;
            default:   w_alu = '0;
        endcase
    end

    // Stage 1: decode and operand capture; illegal or absent instructions become bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_rd    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_c     <= '0;
            r_s1_imm   <= '0;
        end else begin
            r_s1_valid <= valid_in && w_legal;
            r_s1_op    <= w_op;
            r_s1_rd    <= w_rd;
            r_s1_a     <= w_a;
            r_s1_b     <= w_b;
            r_s1_c     <= w_c;
            r_s1_imm   <= {{(DATA_W-5){w_imm5[4]}}, w_imm5};
        end
    end

    // Stage 2: execute, write back, present result
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= DATA_W'(i);
            end
            result_o     <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= r_s1_valid;
            if (r_s1_valid) begin
                result_o <= w_alu;
                if (r_s1_rd != 5'd0) begin
                    r_regs[r_s1_rd] <= w_alu;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_core
// Purpose  : Directed self-checking bench for pe_core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_core;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        valid_in;
    logic [31:0] result_o;
    logic        result_valid;

    int n_checks;
    int n_fail;

    pe_core #(.DATA_W(32), .NREGS(32)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .valid_in     (valid_in),
        .result_o     (result_o),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [4:0] imm);
        return {7'b0000001, op, rd, rs1, rs2, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one instruction, then check the cycle its result should appear.
    task automatic run(input string tag, input logic [31:0] ins,
                       input logic exp_v, input logic [31:0] exp_r);
        @(negedge clk);
        instr = ins;
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, {31'd0, result_valid}, {31'd0, exp_v});
        chk({tag, "_result"}, result_o, exp_r);
    endtask

    // Observe register x non-destructively via ADD r0 = rx + r0.
    task automatic read_reg(input string tag, input logic [4:0] x, input logic [31:0] exp);
        run(tag, enc(5'h01, 5'd0, x, 5'd0, 5'd0), 1'b1, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        valid_in = 1'b0;
        instr    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, result_valid}, 32'd0);
        chk("reset_result", result_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single ADD, then hold
        run("add", enc(5'h01, 5'd1, 5'd2, 5'd3, 5'd0), 1'b1, 32'd5);
        @(posedge clk);
        #1;
        chk("hold_valid", {31'd0, result_valid}, 32'd0);
        chk("hold_result", result_o, 32'd5);

        // Back-to-back dependency from fresh state (r1 = 1 without forwarding)
        do_reset();
        @(negedge clk);
        instr = enc(5'h01, 5'd1, 5'd2, 5'd3, 5'd0);
        valid_in = 1'b1;
        @(negedge clk);
        instr = enc(5'h01, 5'd4, 5'd1, 5'd1, 5'd0);
        @(posedge clk);
        #1;
        chk("b2b1_valid", {31'd0, result_valid}, 32'd1);
        chk("b2b1_result", result_o, 32'd5);
        @(negedge clk);
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b2_valid", {31'd0, result_valid}, 32'd1);
        chk("b2b2_result", result_o, 32'd10);
        @(posedge clk);
        #1;
        chk("b2b_idle_valid", {31'd0, result_valid}, 32'd0);

        // Arithmetic and shifts (r4 = 10)
        run("sub",  enc(5'h02, 5'd5,  5'd2, 5'd3, 5'd0), 1'b1, 32'hFFFF_FFFF);
        run("sra",  enc(5'h09, 5'd8,  5'd5, 5'd4, 5'd0), 1'b1, 32'hFFFF_FFFF);
        run("srl",  enc(5'h08, 5'd13, 5'd5, 5'd4, 5'd0), 1'b1, 32'h003F_FFFF);
        run("relu_neg", enc(5'h0D, 5'd9, 5'd5, 5'd0, 5'd0), 1'b1, 32'd0);
        run("relu_pos", enc(5'h0D, 5'd9, 5'd3, 5'd0, 5'd0), 1'b1, 32'd3);

        // Back-to-back MAC on the same rd (r6 = 6): 12 then 18
        @(negedge clk);
        instr = enc(5'h0C, 5'd6, 5'd2, 5'd3, 5'd0);
        valid_in = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("mac1", result_o, 32'd12);
        @(negedge clk);
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        chk("mac2", result_o, 32'd18);

        run("mul",  enc(5'h03, 5'd7, 5'd31, 5'd31, 5'd0), 1'b1, 32'd961);
        run("addi", enc(5'h0E, 5'd1, 5'd0, 5'd0, 5'b11111), 1'b1, 32'hFFFF_FFFF);
        run("and",  enc(5'h04, 5'd10, 5'd12, 5'd10, 5'd0), 1'b1, 32'd8);
        run("or",   enc(5'h05, 5'd11, 5'd12, 5'd3, 5'd0), 1'b1, 32'd15);
        run("xor",  enc(5'h06, 5'd14, 5'd12, 5'd15, 5'd0), 1'b1, 32'd3);
        run("sll",  enc(5'h07, 5'd11, 5'd3, 5'd2, 5'd0), 1'b1, 32'd12);
        run("max",  enc(5'h0A, 5'd16, 5'd5, 5'd3, 5'd0), 1'b1, 32'd3);
        run("min",  enc(5'h0B, 5'd17, 5'd5, 5'd3, 5'd0), 1'b1, 32'hFFFF_FFFF);

        // Illegal instructions targeting r3: no valid, result_o held
        run("ill_class", {7'b0000000, 5'h01, 5'd3, 5'd1, 5'd1, 5'd0}, 1'b0, 32'hFFFF_FFFF);
        run("ill_op1f",  enc(5'h1F, 5'd3, 5'd1, 5'd1, 5'd0), 1'b0, 32'hFFFF_FFFF);
        run("ill_op00",  enc(5'h00, 5'd3, 5'd1, 5'd1, 5'd0), 1'b0, 32'hFFFF_FFFF);
        read_reg("r3_kept", 5'd3, 32'd3);

        // Reset with an instruction in stage 1
        @(negedge clk);
        instr = enc(5'h01, 5'd2, 5'd31, 5'd31, 5'd0);
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_mid_result", result_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_valid2", {31'd0, result_valid}, 32'd0);
        read_reg("r1_reload", 5'd1, 32'd1);
        read_reg("r2_reload", 5'd2, 32'd2);

        // Reset dominates a simultaneous valid instruction
        @(negedge clk);
        instr = enc(5'h01, 5'd5, 5'd31, 5'd31, 5'd0);
        valid_in = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_dom_valid", {31'd0, result_valid}, 32'd0);
        read_reg("r5_reload", 5'd5, 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
